core_monitor: RTL and testbench
===============================

# core_monitor

Synthesizable run monitor that sits directly downstream of `core`. It watches the fetch stream, stall, flush, BHT and store activity, and detects program completion when the fetched instruction stays unchanged. After completion it drives the core's console port (`con_addr`/`con_out`) to dump every written data word and accumulates a checksum. This replaces testbench-only completion and performance logic with hardware that can also run on the FPGA.

## Interface

Parameters:
- `IDLE_LIMIT`, 50: number of consecutive repeated-instruction cycles that declares the program done.
- `CNT_W`, 32: width of every performance counter.

Ports:
- `CLK` in 1: clock; all state changes on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `if_inst` in 32: instruction currently in IF.
- `if_stall` in 1: pipeline stalled this cycle.
- `isr_pc_flush`, `isr_pipe_flush`, `branch_flush` in 1 each: flush sources.
- `bht_access` in 1: a branch or jump is in ID this cycle.
- `bht_correct` in 2: number of correct predictions resolved this cycle (0–2).
- `store_valid` in 1: a store with a nonzero byte mask is in EXE.
- `store_addr` in 11: word address of that store (`ALUout[12:2]`).
- `con_out` in 32: data memory read data; 1-cycle latency from `con_addr`.
- `con_addr` out 10: data memory console read address.
- `done` out 1: completion detected.
- `dump_valid` out 1: `dump_addr`/`dump_data` hold a dumped word this cycle.
- `dump_addr` out 10, `dump_data` out 32: the dumped word and its address.
- `dump_done` out 1: dump complete; `checksum` is final.
- `checksum` out 32: running dump checksum.
- `rd_sel` in 3, `rd_data` out 32: counter readback (combinational mux).

## Operation

- **States:** RUN → DUMP → FIN. Reset enters RUN. FIN is terminal until reset.
- **RUN:**
  - `last_inst` resets to 0.
  - Each cycle, if `if_inst == last_inst`, `idle_cnt` is incremented. Otherwise `idle_cnt` is set to 0 and `last_inst` is set to `if_inst`.
  - When the registered `idle_cnt == IDLE_LIMIT`, the next edge enters DUMP.
- **Counters** update only in RUN, and all saturate at all-ones:
  - `cycles`: +1 every cycle.
  - `stalls`: +1 when `if_stall`.
  - `flushes`: +1 when any flush input is high.
  - `bht_acc`: +1 when `bht_access`.
  - `bht_ok`: + `bht_correct`.
  - `nops` (optional): +1 when `if_inst[15:0]==16'h0001` or `if_inst==32'h00000013`.
- **max_addr:** in RUN, when `store_valid` and `store_addr > max_addr`, `max_addr` takes `store_addr[9:0]`. Resets to 0.
- **DUMP:**
  - `con_addr` starts at 0 and increments each cycle until it equals `max_addr`, then holds.
  - A one-cycle valid pipeline pairs each address with `con_out` on the following cycle.
  - On each valid word: `checksum <= {checksum[30:0],checksum[31]} + con_out`, mod 2^32.
  - When the word at `max_addr` has been accumulated, the next edge enters FIN.
- **rd_sel:**
  - 0 → `cycles - IDLE_LIMIT`, saturating at 0.
  - 1 → `stalls`; 2 → `flushes`; 3 → `nops`; 4 → `bht_acc`; 5 → `bht_ok`.
  - 6 → `{22'b0,max_addr}`; 7 → `checksum`.
- `done` = state is DUMP or FIN. `dump_done` = state is FIN.

## Timing

- **Reset values:**
  - `con_addr`=0, `done`=0, `dump_valid`=0, `dump_addr`=0, `dump_data`=0, `dump_done`=0, `checksum`=0.
  - All counters, `idle_cnt`, `last_inst` and `max_addr` are 0.
- **Completion:** with a constant `if_inst` X≠`last_inst`, `last_inst` is loaded on edge 1. `idle_cnt` reaches `IDLE_LIMIT` on edge 1+`IDLE_LIMIT`, and `done` rises on the following edge.
- **Dump latency:**
  - The first `dump_valid` occurs 2 edges after DUMP entry.
  - (`max_addr`+1) words are emitted on consecutive cycles, with no gaps.
  - `dump_done` rises 1 edge after the last `dump_valid`.
- **Boundary cases:**
  - With no stores, `max_addr`=0 and exactly one word (address 0) is dumped.
  - A store in the same cycle as the RUN→DUMP transition edge is still counted, because it is sampled in RUN.
  - Counter saturation never wraps.
  - Asynchronous reset mid-DUMP clears everything and restarts RUN. `con_addr` drops to 0 immediately.
  - `if_inst` equal to 0 right after reset counts as idle. This is intended: the core fetches nonzero instructions well before `IDLE_LIMIT`.

## Configuration

- `CORE_MONITOR_NOP_COUNT_EN`:
  - Defined: the NOP detector and `nops` counter are built.
  - Undefined: no NOP logic exists and `rd_sel`=3 returns 0.

## Test plan

- **Completion timing:** reset, drive `if_inst` incrementing for 20 cycles, then hold 0x00000063 → `done` rises exactly `IDLE_LIMIT`+2 edges after the hold begins; `rd_sel`=0 reads 21 (±1 per the cycle definition, checked against the model).
- **Counters:** in RUN, pulse `if_stall` for 7 cycles, `branch_flush` for 3 cycles with `isr_pipe_flush` overlapping 1 of them, `bht_access` ×5, and `bht_correct`=2 once plus =1 twice → stalls=7, flushes=3, bht_acc=5, bht_ok=4.
- **Dump:** stores at word addresses 3, 9, 5, then memory model word k = k+1 → `max_addr`=9; 10 `dump_valid` pulses for addresses 0..9; `checksum` matches the rotate-add model; `dump_done` 1 cycle after address 9.
- **No stores:** complete with no stores → single dump word at address 0, `dump_done` 3 edges after `done`.
- **Reset mid-dump:** assert `nrst`=0 on the 4th `dump_valid` → all outputs are at reset values before the next edge; the run is redone cleanly.
- **Macro:** with `CORE_MONITOR_NOP_COUNT_EN`, 4 cycles of `if_inst`=0x00000013 and 2 of 0x00010001 → nops=6; without the macro → `rd_sel`=3 reads 0.

Source files
------------

// File: rtl/core_monitor.sv
// core_monitor: watches the fetch stream, declares completion after IDLE_LIMIT repeated fetches, then dumps data words 0..max_addr over the console port.
// Latency: first dump word 2 edges after done, one word per cycle, no backpressure; optional NOP counter under CORE_MONITOR_NOP_COUNT_EN.
module core_monitor #(
  parameter int IDLE_LIMIT = 50,
  parameter int CNT_W      = 32
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic [31:0] if_inst,
  input  logic        if_stall,
  input  logic        isr_pc_flush,
  input  logic        isr_pipe_flush,
  input  logic        branch_flush,
  input  logic        bht_access,
  input  logic [1:0]  bht_correct,
  input  logic        store_valid,
  input  logic [10:0] store_addr,
  input  logic [31:0] con_out,
  output logic [9:0]  con_addr,
  output logic        done,
  output logic        dump_valid,
  output logic [9:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic [31:0] checksum,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data
);

  localparam int                IDLE_W   = $clog2(IDLE_LIMIT + 2);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_LIMIT);
  localparam logic [32:0]       LIM33    = 33'(IDLE_LIMIT);

  typedef enum logic [1:0] {RUN, DUMP, FIN} state_t;

  state_t            state;
  logic [31:0]       last_inst;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  cycles, stalls, flushes, bht_acc, bht_ok;
  logic [9:0]        max_addr;
  logic              issued_all;
  logic              req_vld;
  logic [9:0]        req_addr;
  logic [32:0]       cyc_ext;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state     <= RUN;
      done      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      case (state)
        RUN: if (idle_cnt == IDLE_END) begin
          state <= DUMP;
          done  <= 1'b1;
        end
        DUMP: if (dump_valid && dump_addr == max_addr) begin
          state     <= FIN;
          dump_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      last_inst <= '0;
      idle_cnt  <= '0;
      cycles    <= '0;
      stalls    <= '0;
      flushes   <= '0;
      bht_acc   <= '0;
      bht_ok    <= '0;
      max_addr  <= '0;
    end else if (state == RUN) begin
      cycles <= sat_add(cycles, CNT_W'(1));
      if (if_stall)
        stalls <= sat_add(stalls, CNT_W'(1));
      if (isr_pc_flush || isr_pipe_flush || branch_flush)
        flushes <= sat_add(flushes, CNT_W'(1));
      if (bht_access)
        bht_acc <= sat_add(bht_acc, CNT_W'(1));
      bht_ok <= sat_add(bht_ok, CNT_W'(bht_correct));
      // Compare all 11 address bits, but only the low 10 address the dump window.
      if (store_valid && store_addr > {1'b0, max_addr})
        max_addr <= store_addr[9:0];
      if (if_inst == last_inst) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt  <= '0;
        last_inst <= if_inst;
      end
    end
  end

`ifdef CORE_MONITOR_NOP_COUNT_EN
  logic [CNT_W-1:0] nops;
  logic             is_nop;

  assign is_nop = (if_inst[15:0] == 16'h0001) || (if_inst == 32'h0000_0013);

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst)
      nops <= '0;
    else if (state == RUN && is_nop)
      nops <= sat_add(nops, CNT_W'(1));
  end
`endif

  // req_* tracks the address presented last cycle so it lines up with con_out.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      con_addr   <= '0;
      issued_all <= 1'b0;
      req_vld    <= 1'b0;
      req_addr   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      checksum   <= '0;
    end else begin
      if (state == DUMP) begin
        req_vld  <= !issued_all;
        req_addr <= con_addr;
        if (!issued_all && con_addr == max_addr)
          issued_all <= 1'b1;
        if (con_addr != max_addr)
          con_addr <= con_addr + 10'd1;
      end else begin
        req_vld <= 1'b0;
      end
      dump_valid <= req_vld;
      if (req_vld) begin
        dump_addr <= req_addr;
        dump_data <= con_out;
        checksum  <= {checksum[30:0], checksum[31]} + con_out;
      end
    end
  end

  assign cyc_ext = 33'(cycles);

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      3'd0: rd_data = (cyc_ext > LIM33) ? 32'(cyc_ext - LIM33) : 32'd0;
      3'd1: rd_data = 32'(stalls);
      3'd2: rd_data = 32'(flushes);
`ifdef CORE_MONITOR_NOP_COUNT_EN
      3'd3: rd_data = 32'(nops);
`else
      3'd3: rd_data = 32'd0;
`endif
      3'd4: rd_data = 32'(bht_acc);
      3'd5: rd_data = 32'(bht_ok);
      3'd6: rd_data = {22'b0, max_addr};
      default: rd_data = checksum;
    endcase
  end

endmodule

// File: tb/tb_core_monitor.sv
// Self-checking bench for core_monitor: randomized runs against a stimulus-side reference model.
module tb_core_monitor;
  localparam int L = 50;

  logic        CLK = 1'b0;
  logic        nrst;
  logic [31:0] if_inst;
  logic        if_stall, isr_pc_flush, isr_pipe_flush, branch_flush, bht_access;
  logic [1:0]  bht_correct;
  logic        store_valid;
  logic [10:0] store_addr;
  logic [31:0] con_out, con_out_s;
  logic [2:0]  rd_sel;
  logic [9:0]  con_addr, dump_addr, con_addr_s, dump_addr_s;
  logic        done, dump_valid, dump_done, done_s, dump_valid_s, dump_done_s;
  logic [31:0] dump_data, checksum, rd_data, dump_data_s, checksum_s, rd_data_s;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  int          m_cycles, m_stalls, m_flushes, m_acc, m_ok, m_nops, m_max, m_rl;
  logic [31:0] m_prev;
  bit          m_done;

  int          w_n, w_first, w_last, w_done_t;
  bit          w_contig, w_to;
  int          w_addr[$];
  logic [31:0] w_data[$];
  logic [31:0] w_cs;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    con_out   <= mem[con_addr];
    con_out_s <= mem[con_addr_s];
  end

  core_monitor #(.IDLE_LIMIT(L), .CNT_W(32)) dut (
    .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .if_stall(if_stall),
    .isr_pc_flush(isr_pc_flush), .isr_pipe_flush(isr_pipe_flush), .branch_flush(branch_flush),
    .bht_access(bht_access), .bht_correct(bht_correct), .store_valid(store_valid),
    .store_addr(store_addr), .con_out(con_out), .con_addr(con_addr), .done(done),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done), .checksum(checksum), .rd_sel(rd_sel), .rd_data(rd_data)
  );

  core_monitor #(.IDLE_LIMIT(L), .CNT_W(4)) dut_s (
    .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .if_stall(if_stall),
    .isr_pc_flush(isr_pc_flush), .isr_pipe_flush(isr_pipe_flush), .branch_flush(branch_flush),
    .bht_access(bht_access), .bht_correct(bht_correct), .store_valid(store_valid),
    .store_addr(store_addr), .con_out(con_out_s), .con_addr(con_addr_s), .done(done_s),
    .dump_valid(dump_valid_s), .dump_addr(dump_addr_s), .dump_data(dump_data_s),
    .dump_done(dump_done_s), .checksum(checksum_s), .rd_sel(rd_sel), .rd_data(rd_data_s)
  );

  function automatic logic [31:0] mk_inst(input int i);
    logic [7:0] r;
    r = 8'($urandom);
    return {r, 16'(i), 8'h33};
  endfunction

  function automatic logic [31:0] exp_cs(input int maxa);
    logic [31:0] c;
    c = '0;
    for (int a = 0; a <= maxa; a++) c = {c[30:0], c[31]} + mem[a];
    return c;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic do_reset();
    nrst = 1'b0;
    if_inst = '0; if_stall = 0; isr_pc_flush = 0; isr_pipe_flush = 0; branch_flush = 0;
    bht_access = 0; bht_correct = 0; store_valid = 0; store_addr = '0; rd_sel = 0;
    repeat (2) @(posedge CLK);
    #1 nrst = 1'b1;
    m_cycles = 0; m_stalls = 0; m_flushes = 0; m_acc = 0; m_ok = 0; m_nops = 0;
    m_max = 0; m_rl = 0; m_prev = '0; m_done = 0;
  endtask

  // One RUN cycle: drive inputs, account them in the model, advance past the edge.
  task automatic step(input logic [31:0] inst, input logic stall, input logic [2:0] fl,
                      input logic acc, input logic [1:0] corr, input logic sv,
                      input logic [10:0] sa);
    if_inst = inst; if_stall = stall;
    isr_pc_flush = fl[0]; isr_pipe_flush = fl[1]; branch_flush = fl[2];
    bht_access = acc; bht_correct = corr; store_valid = sv; store_addr = sa;
    if (!m_done) begin
      m_cycles++;
      if (stall) m_stalls++;
      if (fl != 3'b0) m_flushes++;
      if (acc) m_acc++;
      m_ok += int'(corr);
      if (inst[15:0] == 16'h0001 || inst == 32'h13) m_nops++;
      if (sv && int'(sa) > m_max) m_max = int'(sa);
      if (m_rl == L) m_done = 1;
      else if (inst == m_prev) m_rl++;
      else begin m_rl = 0; m_prev = inst; end
    end
    @(posedge CLK);
    #1;
    store_valid = 0;
  endtask

  task automatic run_hold(input logic [31:0] h, input logic xsv, input logic [10:0] xsa);
    int g = 0;
    while (!m_done && g < 400) begin
      step(h, 0, 3'b0, 0, 2'd0, (m_rl == L) ? xsv : 1'b0, xsa);
      g++;
    end
  endtask

  task automatic watch_dump();
    int t = 0;
    w_n = 0; w_first = -1; w_last = -1; w_done_t = -1; w_contig = 1; w_to = 1; w_cs = '0;
    w_addr.delete(); w_data.delete();
    while (t < 3000) begin
      @(posedge CLK);
      #1;
      t++;
      if (dump_valid) begin
        if (w_n > 0 && t != w_last + 1) w_contig = 0;
        if (w_n == 0) w_first = t;
        w_last = t;
        w_n++;
        w_addr.push_back(int'(dump_addr));
        w_data.push_back(dump_data);
      end
      if (dump_done) begin
        w_done_t = t; w_cs = checksum; w_to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({con_addr, done, dump_valid, dump_addr, dump_data, dump_done, checksum} !== '0) begin
      errors++; $display("FAIL reset_outputs: con_addr=%0d done=%b vld=%b addr=%0d data=%h ddone=%b cs=%h, want all 0",
                         con_addr, done, dump_valid, dump_addr, dump_data, dump_done, checksum);
    end
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      checks++; if (rd_data !== 32'd0 || rd_data_s !== 32'd0) begin
        errors++; $display("FAIL reset_rd sel=%0d: got %h/%h want 0", s, rd_data, rd_data_s);
      end
    end
  endtask

  task automatic test_completion();
    int he = 0;
    int rise = -1;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(32'(i), 0, 3'b0, 0, 2'd0, 0, '0);
      checks++; if (done !== 1'b0) begin
        errors++; $display("FAIL early_done cycle %0d: got %b want 0", i, done);
      end
    end
    while (!m_done && he < 200) begin
      step(32'h0000_0063, 0, 3'b0, 0, 2'd0, 0, '0);
      he++;
      checks++; if (done !== m_done) begin
        errors++; $display("FAIL done_track hold edge %0d: got %b want %b", he, done, m_done);
      end
      if (done === 1'b1 && rise < 0) rise = he;
    end
    checks++; if (rise != L + 2) begin
      errors++; $display("FAIL done_latency: rose at hold edge %0d want %0d", rise, L + 2);
    end
    rd_sel = 3'd0;
    #1;
    checks++; if (rd_data !== 32'(m_cycles - L)) begin
      errors++; $display("FAIL rd_cycles: got %0d want %0d", rd_data, m_cycles - L);
    end
  endtask

  task automatic test_counters();
    int s0 = $urandom_range(0, 20);
    int f0 = $urandom_range(0, 25);
    int fp = f0 + $urandom_range(0, 2);
    int a0 = $urandom_range(0, 5);
    int c0 = $urandom_range(0, 20);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      logic st, ac;
      logic [2:0] fl;
      logic [1:0] co;
      st = (i >= s0 && i < s0 + 7);
      fl = {(i >= f0 && i < f0 + 3), (i == fp), 1'b0};
      ac = (i % 6 == a0);
      co = (i == c0) ? 2'd2 : ((i == c0 + 3 || i == c0 + 7) ? 2'd1 : 2'd0);
      step(mk_inst(i + 1), st, fl, ac, co, 0, '0);
    end
    run_hold(32'h0000_0063, 0, '0);
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'(m_stalls)) begin errors++; $display("FAIL stalls: got %0d want %0d", rd_data, m_stalls); end
    rd_sel = 3'd2; #1;
    checks++; if (rd_data !== 32'(m_flushes)) begin errors++; $display("FAIL flushes: got %0d want %0d", rd_data, m_flushes); end
    rd_sel = 3'd4; #1;
    checks++; if (rd_data !== 32'(m_acc)) begin errors++; $display("FAIL bht_acc: got %0d want %0d", rd_data, m_acc); end
    rd_sel = 3'd5; #1;
    checks++; if (rd_data !== 32'(m_ok)) begin errors++; $display("FAIL bht_ok: got %0d want %0d", rd_data, m_ok); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++)
      step(mk_inst(i + 1), ($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom),
           2'($urandom_range(0, 2)), 0, '0);
    run_hold(32'h0000_0063, 0, '0);
    rd_sel = 3'd1; #1;
    checks++; if (rd_data !== 32'(m_stalls) || rd_data_s !== 32'(sat15(m_stalls))) begin
      errors++; $display("FAIL sat_stalls: got %0d/%0d want %0d/%0d", rd_data, rd_data_s, m_stalls, sat15(m_stalls));
    end
    rd_sel = 3'd2; #1;
    checks++; if (rd_data !== 32'(m_flushes) || rd_data_s !== 32'(sat15(m_flushes))) begin
      errors++; $display("FAIL sat_flushes: got %0d/%0d want %0d/%0d", rd_data, rd_data_s, m_flushes, sat15(m_flushes));
    end
    rd_sel = 3'd4; #1;
    checks++; if (rd_data !== 32'(m_acc) || rd_data_s !== 32'(sat15(m_acc))) begin
      errors++; $display("FAIL sat_bht_acc: got %0d/%0d want %0d/%0d", rd_data, rd_data_s, m_acc, sat15(m_acc));
    end
    rd_sel = 3'd5; #1;
    checks++; if (rd_data !== 32'(m_ok) || rd_data_s !== 32'(sat15(m_ok))) begin
      errors++; $display("FAIL sat_bht_ok: got %0d/%0d want %0d/%0d", rd_data, rd_data_s, m_ok, sat15(m_ok));
    end
    rd_sel = 3'd0; #1;
    checks++; if (rd_data !== 32'(m_cycles - L) || rd_data_s !== 32'd0) begin
      errors++; $display("FAIL sat_cycles: got %0d/%0d want %0d/0", rd_data, rd_data_s, m_cycles - L);
    end
  endtask

  task automatic test_dump();
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k + 1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic sv;
      logic [10:0] sa;
      sv = (i == 2 || i == 5 || i == 8);
      sa = (i == 2) ? 11'd3 : (i == 5) ? 11'd9 : (i == 8) ? 11'd5 : 11'd1000;
      step(mk_inst(i + 1), 0, 3'b0, 0, 2'd0, sv, sa);
    end
    run_hold(32'h0000_0063, 0, '0);
    rd_sel = 3'd6; #1;
    checks++; if (rd_data !== 32'(m_max)) begin errors++; $display("FAIL max_addr: got %0d want %0d", rd_data, m_max); end
    watch_dump();
    checks++; if (w_to) begin errors++; $display("FAIL dump_timeout: dump_done never rose"); end
    checks++; if (w_n != m_max + 1) begin errors++; $display("FAIL dump_count: got %0d want %0d", w_n, m_max + 1); end
    checks++; if (w_first != 2 || !w_contig) begin
      errors++; $display("FAIL dump_timing: first at %0d contiguous=%0d want 2/1", w_first, w_contig);
    end
    checks++; if (w_done_t != w_last + 1) begin
      errors++; $display("FAIL dump_done_lat: done at %0d last valid %0d", w_done_t, w_last);
    end
    for (int i = 0; i < w_n && i <= m_max; i++) begin
      checks++; if (w_addr[i] != i || w_data[i] !== mem[i]) begin
        errors++; $display("FAIL dump_word %0d: addr %0d data %h want %0d %h", i, w_addr[i], w_data[i], i, mem[i]);
      end
    end
    checks++; if (w_cs !== exp_cs(m_max)) begin errors++; $display("FAIL checksum: got %h want %h", w_cs, exp_cs(m_max)); end
    checks++; if (con_addr !== 10'(m_max)) begin errors++; $display("FAIL con_addr_hold: got %0d want %0d", con_addr, m_max); end
  endtask

  task automatic test_no_stores();
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    do_reset();
    for (int i = 0; i < 15; i++) step(mk_inst(i + 1), 1'($urandom), 3'b0, 0, 2'd0, 0, '0);
    run_hold(32'h0000_0063, 0, '0);
    watch_dump();
    checks++; if (w_n != 1 || w_addr.size() < 1 || w_addr[0] != 0) begin
      errors++; $display("FAIL nostore_words: got %0d words want 1 at addr 0", w_n);
    end
    checks++; if (w_done_t != 3) begin errors++; $display("FAIL nostore_done_lat: got %0d want 3", w_done_t); end
    checks++; if (w_cs !== mem[0]) begin errors++; $display("FAIL nostore_cs: got %h want %h", w_cs, mem[0]); end
  endtask

  task automatic test_store_on_exit();
    logic [10:0] xa = 11'($urandom_range(10, 40));
    do_reset();
    for (int i = 0; i < 8; i++) step(mk_inst(i + 1), 0, 3'b0, 0, 2'd0, (i == 3), 11'd4);
    run_hold(32'h0000_0063, 1'b1, xa);
    rd_sel = 3'd6; #1;
    checks++; if (rd_data !== 32'(m_max)) begin errors++; $display("FAIL exit_store_max: got %0d want %0d", rd_data, m_max); end
    watch_dump();
    checks++; if (w_n != m_max + 1 || w_cs !== exp_cs(m_max)) begin
      errors++; $display("FAIL exit_store_dump: %0d words cs %h want %0d cs %h", w_n, w_cs, m_max + 1, exp_cs(m_max));
    end
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    int g = 0;
    do_reset();
    for (int i = 0; i < 10; i++)
      step(mk_inst(i + 1), 0, 3'b0, 0, 2'd0, (i == 4), 11'($urandom_range(6, 20)));
    run_hold(32'h0000_0063, 0, '0);
    while (n < 4 && g < 100) begin
      @(posedge CLK);
      #1;
      g++;
      if (dump_valid) n++;
    end
    checks++; if (n < 4) begin errors++; $display("FAIL middump_wait: saw %0d dump words want 4", n); end
    #2 nrst = 1'b0;
    #1;
    checks++; if ({con_addr, done, dump_valid, dump_addr, dump_data, dump_done, checksum} !== '0) begin
      errors++; $display("FAIL middump_outputs: con_addr=%0d done=%b vld=%b addr=%0d data=%h ddone=%b cs=%h, want all 0",
                         con_addr, done, dump_valid, dump_addr, dump_data, dump_done, checksum);
    end
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL middump_rd sel=%0d: got %h want 0", s, rd_data); end
    end
    do_reset();
    for (int i = 0; i < 10; i++)
      step(mk_inst(i + 100), 0, 3'b0, 0, 2'd0, (i == 6), 11'($urandom_range(3, 12)));
    run_hold(32'h0000_0063, 0, '0);
    watch_dump();
    checks++; if (w_to || w_n != m_max + 1 || w_cs !== exp_cs(m_max)) begin
      errors++; $display("FAIL middump_redo: to=%0d %0d words cs %h want %0d cs %h", w_to, w_n, w_cs, m_max + 1, exp_cs(m_max));
    end
  endtask

  task automatic test_nop();
    int exp_n, exp_s;
    do_reset();
    for (int i = 0; i < 5; i++) step(mk_inst(i + 1), 0, 3'b0, 0, 2'd0, 0, '0);
    for (int i = 0; i < 4; i++) step(32'h0000_0013, 0, 3'b0, 0, 2'd0, 0, '0);
    for (int i = 0; i < 3; i++) step(mk_inst(i + 10), 0, 3'b0, 0, 2'd0, 0, '0);
    for (int i = 0; i < 2; i++) step(32'h0001_0001, 0, 3'b0, 0, 2'd0, 0, '0);
    step(mk_inst(20), 0, 3'b0, 0, 2'd0, 0, '0);
    run_hold(32'h0000_0063, 0, '0);
`ifdef CORE_MONITOR_NOP_COUNT_EN
    exp_n = m_nops;
    exp_s = sat15(m_nops);
`else
    exp_n = 0;
    exp_s = 0;
`endif
    rd_sel = 3'd3; #1;
    checks++; if (rd_data !== 32'(exp_n) || rd_data_s !== 32'(exp_s)) begin
      errors++; $display("FAIL nops: got %0d/%0d want %0d/%0d", rd_data, rd_data_s, exp_n, exp_s);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    test_reset();
    test_completion();
    test_counters();
    test_saturation();
    test_dump();
    test_no_stores();
    test_store_on_exit();
    test_reset_mid_dump();
    test_nop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
